// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master request port between NUM_REQ requesters.
// The grant is held until the transfer completes: a write at master acceptance, a read on data return or timeout.
module apb_req_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                            i_clk_apb,
   input  logic                            i_rstn_apb,
   input  logic [NUM_REQ-1:0]              i_req_valid,
   input  logic [NUM_REQ-1:0]              i_req_rd0_wr1,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   i_req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_wr_data,
   output logic [NUM_REQ-1:0]              o_req_ready,
   output logic [DATA_WIDTH-1:0]           o_req_rd_data,
   output logic [NUM_REQ-1:0]              o_req_rd_valid,
   output logic [NUM_REQ-1:0]              o_req_err,
   output logic                            o_m_valid,
   output logic                            o_m_rd0_wr1,
   output logic [ADDR_WIDTH-1:0]           o_m_addr,
   output logic [DATA_WIDTH-1:0]           o_m_wr_data,
   input  logic                            i_m_ready,
   input  logic [DATA_WIDTH-1:0]           i_m_rd_data,
   input  logic                            i_m_rd_valid,
   output logic [$clog2(NUM_REQ)-1:0]      o_grant_id,
   output logic                            o_busy
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

   state_t        state;
   logic [IW-1:0] ptr;
   logic [CW-1:0] cnt;
   logic          found;
   logic [IW-1:0] winner;

   // First valid requester strictly after the last winner, wrapping around.
   always_comb begin
      logic [IW-1:0] idx;
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = IW'((int'(ptr) + i) % NUM_REQ);
         if (!found && i_req_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      o_req_ready = '0;
      if (state == IDLE && i_rstn_apb && found)
         o_req_ready[winner] = 1'b1;
   end

   assign o_busy = (state != IDLE);

   always_ff @(posedge i_clk_apb) begin
      if (!i_rstn_apb) begin
         state          <= IDLE;
         ptr            <= IW'(NUM_REQ - 1);
         cnt            <= '0;
         o_grant_id     <= '0;
         o_m_valid      <= 1'b0;
         o_m_rd0_wr1    <= 1'b0;
         o_m_addr       <= '0;
         o_m_wr_data    <= '0;
         o_req_rd_valid <= '0;
         o_req_err      <= '0;
         o_req_rd_data  <= '0;
      end else begin
         o_req_rd_valid <= '0;
         o_req_err      <= '0;
         case (state)
            IDLE: begin
               if (found) begin
                  o_m_rd0_wr1 <= i_req_rd0_wr1[winner];
                  o_m_addr    <= i_req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                  o_m_wr_data <= i_req_wr_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                  ptr         <= winner;
                  o_grant_id  <= winner;
                  o_m_valid   <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (i_m_ready) begin
                  o_m_valid <= 1'b0;
                  cnt       <= '0;
                  state     <= o_m_rd0_wr1 ? IDLE : WAIT_RD;
               end
            end
            WAIT_RD: begin
               cnt <= cnt + CW'(1);
               // Returned data takes priority over a timeout landing in the same cycle.
               if (i_m_rd_valid) begin
                  o_req_rd_valid[o_grant_id] <= 1'b1;
                  o_req_rd_data              <= i_m_rd_data;
                  state                      <= IDLE;
               end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1)) begin
                  o_req_rd_valid[o_grant_id] <= 1'b1;
                  o_req_err[o_grant_id]      <= 1'b1;
                  o_req_rd_data              <= '0;
                  state                      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomized scoreboard bench for apb_req_arbiter: a transaction-level model predicts grants,
// master handshakes and read completions; a negedge monitor pops and compares them.
module tb_apb_req_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 16;

   logic              clk;
   logic              rstn;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_rd0_wr1;
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_wr_data;
   logic [N-1:0]      req_ready;
   logic [DW-1:0]     req_rd_data;
   logic [N-1:0]      req_rd_valid;
   logic [N-1:0]      req_err;
   logic              m_valid;
   logic              m_rd0_wr1;
   logic [AW-1:0]     m_addr;
   logic [DW-1:0]     m_wr_data;
   logic              m_ready;
   logic [DW-1:0]     m_rd_data;
   logic              m_rd_valid;
   logic [1:0]        grant_id;
   logic              busy;

   apb_req_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .i_clk_apb     (clk),
      .i_rstn_apb    (rstn),
      .i_req_valid   (req_valid),
      .i_req_rd0_wr1 (req_rd0_wr1),
      .i_req_addr    (req_addr),
      .i_req_wr_data (req_wr_data),
      .o_req_ready   (req_ready),
      .o_req_rd_data (req_rd_data),
      .o_req_rd_valid(req_rd_valid),
      .o_req_err     (req_err),
      .o_m_valid     (m_valid),
      .o_m_rd0_wr1   (m_rd0_wr1),
      .o_m_addr      (m_addr),
      .o_m_wr_data   (m_wr_data),
      .i_m_ready     (m_ready),
      .i_m_rd_data   (m_rd_data),
      .i_m_rd_valid  (m_rd_valid),
      .o_grant_id    (grant_id),
      .o_busy        (busy)
   );

   typedef struct {int cyc; int w;} grant_t;
   typedef struct {int cyc; int w; logic dir; logic [AW-1:0] addr; logic [DW-1:0] data;} hs_t;
   typedef struct {int cyc; int w; logic [DW-1:0] data; logic err;} rd_t;

   grant_t exp_grant[$];
   hs_t    exp_hs[$];
   rd_t    exp_rd[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int model_ptr = N - 1;

   logic          tx_dir [N];
   logic [AW-1:0] tx_addr[N];
   logic [DW-1:0] tx_data[N];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int rr_pick(input int last, input logic [N-1:0] mask);
      for (int i = 1; i <= N; i++)
         if (mask[(last + i) % N]) return (last + i) % N;
      return -1;
   endfunction

   // Monitor: every DUT-presented event is matched against the oldest expectation.
   always @(negedge clk) begin
      if (rstn) begin
         if (req_ready != '0) begin
            if (exp_grant.size() == 0) checkOutput("unexpected_grant", 64'(req_ready), 64'd0);
            else begin
               grant_t g;
               g = exp_grant.pop_front();
               checkOutput("grant_onehot", 64'(req_ready), 64'(1) << g.w);
               checkOutput("grant_cycle", 64'(cyc), 64'(g.cyc));
               checkOutput("grant_busy", 64'(busy), 64'd0);
            end
         end
         if (m_valid) begin
            if (exp_hs.size() == 0) checkOutput("unexpected_m_valid", 64'(m_valid), 64'd0);
            else begin
               checkOutput("m_dir", 64'(m_rd0_wr1), 64'(exp_hs[0].dir));
               checkOutput("m_addr", 64'(m_addr), 64'(exp_hs[0].addr));
               if (exp_hs[0].dir) checkOutput("m_wr_data", 64'(m_wr_data), 64'(exp_hs[0].data));
               checkOutput("ready_in_issue", 64'(req_ready), 64'd0);
               if (m_ready) begin
                  hs_t h;
                  h = exp_hs.pop_front();
                  checkOutput("hs_cycle", 64'(cyc), 64'(h.cyc));
                  checkOutput("hs_grant_id", 64'(grant_id), 64'(h.w));
                  checkOutput("hs_busy", 64'(busy), 64'd1);
               end
            end
         end
         if (req_rd_valid != '0) begin
            if (exp_rd.size() == 0) checkOutput("unexpected_rd_valid", 64'(req_rd_valid), 64'd0);
            else begin
               rd_t r;
               r = exp_rd.pop_front();
               checkOutput("rd_valid_onehot", 64'(req_rd_valid), 64'(1) << r.w);
               checkOutput("rd_err", 64'(req_err), r.err ? (64'(1) << r.w) : 64'd0);
               checkOutput("rd_data", 64'(req_rd_data), 64'(r.data));
               checkOutput("rd_cycle", 64'(cyc), 64'(r.cyc));
            end
         end
      end
   end

   task automatic checkIdleZero(input string tag);
      checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
      checkOutput({tag, "_m_valid"}, 64'(m_valid), 64'd0);
      checkOutput({tag, "_m_addr"}, 64'(m_addr), 64'd0);
      checkOutput({tag, "_m_wr_data"}, 64'(m_wr_data), 64'd0);
      checkOutput({tag, "_m_dir"}, 64'(m_rd0_wr1), 64'd0);
      checkOutput({tag, "_rd_valid"}, 64'(req_rd_valid), 64'd0);
      checkOutput({tag, "_err"}, 64'(req_err), 64'd0);
      checkOutput({tag, "_rd_data"}, 64'(req_rd_data), 64'd0);
      checkOutput({tag, "_grant_id"}, 64'(grant_id), 64'd0);
      checkOutput({tag, "_ready"}, 64'(req_ready), 64'd0);
   endtask

   // One full transaction, entered #1 after a clock edge with the DUT idle.
   // rmode: 0 = read data after r cycles, 1 = timeout then a late rd_valid, 2 = reset during the read.
   task automatic applyStimulus(input logic [N-1:0] mask, input int d, input int rmode,
                                input int r, input logic [DW-1:0] rdata);
      int n, w, h;
      n = cyc;
      w = rr_pick(model_ptr, mask);
      model_ptr = w;
      exp_grant.push_back('{n, w});
      exp_hs.push_back('{n + 1 + d, w, tx_dir[w], tx_addr[w], tx_data[w]});
      for (int k = 0; k < N; k++) begin
         req_rd0_wr1[k]           = tx_dir[k];
         req_addr[k*AW +: AW]     = tx_addr[k];
         req_wr_data[k*DW +: DW]  = tx_data[k];
      end
      req_valid = mask;
      @(posedge clk); #1;
      req_valid = '0;
      for (int i = 0; i < d; i++) begin
         req_valid  = N'($urandom);
         m_rd_valid = 1'b1;
         m_rd_data  = $urandom;
         @(posedge clk); #1;
      end
      req_valid  = '0;
      m_rd_valid = 1'b0;
      m_ready    = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
      h = cyc;
      if (tx_dir[w]) return;
      if (rmode == 1) begin
         exp_rd.push_back('{h + TO, w, '0, 1'b1});
         repeat (TO) begin @(posedge clk); #1; end
         m_rd_valid = 1'b1;
         m_rd_data  = $urandom;
         @(posedge clk); #1;
         m_rd_valid = 1'b0;
      end else if (rmode == 2) begin
         repeat (2) begin @(posedge clk); #1; end
         rstn = 1'b0;
         @(posedge clk); #1;
         checkIdleZero("midreset");
         rstn = 1'b1;
         model_ptr = N - 1;
         @(posedge clk); #1;
         m_rd_valid = 1'b1;
         m_rd_data  = 32'hBAD0_BAD0;
         @(posedge clk); #1;
         m_rd_valid = 1'b0;
         repeat (3) begin @(posedge clk); #1; end
      end else begin
         exp_rd.push_back('{h + r + 1, w, rdata, 1'b0});
         repeat (r) begin @(posedge clk); #1; end
         m_rd_valid = 1'b1;
         m_rd_data  = rdata;
         @(posedge clk); #1;
         m_rd_valid = 1'b0;
      end
   endtask

   task automatic randomFields(input int dir_mode);
      for (int k = 0; k < N; k++) begin
         tx_dir[k]  = (dir_mode == 2) ? 1'($urandom) : dir_mode[0];
         tx_addr[k] = $urandom;
         tx_data[k] = $urandom;
      end
   endtask

   initial begin
      rstn = 1'b0; req_valid = '0; req_rd0_wr1 = '0; req_addr = '0; req_wr_data = '0;
      m_ready = 1'b0; m_rd_data = '0; m_rd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkIdleZero("reset");
      rstn = 1'b1;
      @(posedge clk); #1;

      // All four requesters write back to back: grants rotate 0,1,2,3,0.
      for (int t = 0; t < 5; t++) begin
         randomFields(1);
         applyStimulus(4'b1111, 0, 0, 0, '0);
      end

      // Requester 2 reads 0x10, data returns 3 cycles into the wait.
      randomFields(0);
      tx_addr[2] = 32'h10;
      applyStimulus(4'b0100, 0, 0, 3, 32'hDEAD_BEEF);

      // Master stalls 5 cycles with request/rd_valid noise on the inputs.
      randomFields(2);
      applyStimulus(4'b1011, 5, 0, 4, $urandom);

      // Timeout, then data arriving exactly on the last counted cycle.
      randomFields(0);
      applyStimulus(4'b0001, 1, 1, 0, '0);
      randomFields(0);
      applyStimulus(4'b1000, 0, 0, TO - 1, 32'hCAFE_F00D);

      // Requesters 0 and 3 reading continuously alternate.
      for (int t = 0; t < 6; t++) begin
         randomFields(0);
         applyStimulus(4'b1001, 0, 0, $urandom_range(0, 3), $urandom);
      end

      for (int t = 0; t < 50; t++) begin
         int mode;
         randomFields(2);
         mode = ($urandom_range(0, 5) == 0) ? 1 : 0;
         applyStimulus(N'($urandom_range(1, 15)), $urandom_range(0, 3), mode,
                       $urandom_range(0, TO - 1), $urandom);
      end

      // Reset while a read is outstanding; the pointer restarts so requester 0 wins next.
      randomFields(0);
      tx_addr[1] = 32'h0000_0ABC;
      applyStimulus(4'b0010, 0, 2, 0, '0);
      randomFields(1);
      applyStimulus(4'b1111, 0, 0, 0, '0);

      repeat (4) @(posedge clk);
      #1;
      checkOutput("pending_grants", 64'(exp_grant.size()), 64'd0);
      checkOutput("pending_handshakes", 64'(exp_hs.size()), 64'd0);
      checkOutput("pending_reads", 64'(exp_rd.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
